// File: rtl/mb_rtu_rx.sv
// Modbus RTU request receiver (slave side).
// Parses function 0x03 and 0x10 requests, checks the CRC-16/MODBUS residue,
// streams 0x10 payload bytes and signals frame accept/reject.
module mb_rtu_rx #(
   parameter logic [7:0]  SLAVE_ADDR = 8'h01,
   parameter logic [15:0] GAP_CYCLES = 16'd1750,
   parameter logic [7:0]  MAX_BYTES  = 8'd246
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mb_rx_en,
   input  logic [7:0]  mb_rxd,
   output logic [7:0]  mb_fun,
   output logic [15:0] mb_addr,
   output logic [15:0] mb_num,
   output logic        wr_en,
   output logic [7:0]  wr_idx,
   output logic [7:0]  wr_data,
   output logic        rx_done,
   output logic        rx_err
);

   typedef enum logic [2:0] {
      IDLE, RX_HEAD, RX_FIELD, RX_CNT, RX_DATA, RX_CRC, DISCARD
   } state_t;

   // One full byte of CRC-16/MODBUS (reflected 0xA001), all 8 bit-steps at once.
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] crc_q, crc_d;
   logic [15:0] gap_q, gap_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  bcnt_q, bcnt_d;
   logic [7:0]  fun_q, fun_d;
   logic [31:0] field_q, field_d;      // {start address, register count}
   logic        err_flag_q, err_flag_d;
   logic [7:0]  mb_fun_q, mb_fun_d;
   logic [15:0] mb_addr_q, mb_addr_d;
   logic [15:0] mb_num_q, mb_num_d;
   logic        wr_en_q, wr_en_d;
   logic [7:0]  wr_idx_q, wr_idx_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        rx_done_q, rx_done_d;
   logic        rx_err_q, rx_err_d;

   logic [15:0] crc_new;
   logic        expire;

   // A new frame always restarts the CRC, regardless of the stale register value.
   assign crc_new = crc_step((state_q == IDLE) ? 16'hFFFF : crc_q, mb_rxd);
   // A byte in the expiry cycle takes priority over the gap.
   assign expire  = !mb_rx_en && (gap_q == GAP_CYCLES);

   // Inter-byte silence counter, saturating at the gap length.
   always_comb begin
      gap_d = gap_q;
      if (mb_rx_en) begin
         gap_d = 16'd0;
      end else if (gap_q != GAP_CYCLES) begin
         gap_d = gap_q + 16'd1;
      end
   end

   // Frame parser: next state, field capture and output pulses.
   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      cnt_d      = cnt_q;
      bcnt_d     = bcnt_q;
      fun_d      = fun_q;
      field_d    = field_q;
      err_flag_d = err_flag_q;
      mb_fun_d   = mb_fun_q;
      mb_addr_d  = mb_addr_q;
      mb_num_d   = mb_num_q;
      wr_en_d    = 1'b0;
      wr_idx_d   = wr_idx_q;
      wr_data_d  = wr_data_q;
      rx_done_d  = 1'b0;
      rx_err_d   = 1'b0;
      if (mb_rx_en) begin
         crc_d = crc_new;
         case (state_q)
            IDLE: begin
               cnt_d      = 8'd0;
               err_flag_d = 1'b0;
               // Frames for other stations are dropped silently.
               state_d    = (mb_rxd == SLAVE_ADDR) ? RX_HEAD : DISCARD;
            end
            RX_HEAD: begin
               fun_d = mb_rxd;
               cnt_d = 8'd0;
               if (mb_rxd == 8'h03 || mb_rxd == 8'h10) begin
                  state_d = RX_FIELD;
               end else begin
                  state_d    = DISCARD;
                  err_flag_d = 1'b1;
               end
            end
            RX_FIELD: begin
               field_d = {field_q[23:0], mb_rxd};
               if (cnt_q == 8'd3) begin
                  cnt_d   = 8'd0;
                  state_d = (fun_q == 8'h03) ? RX_CRC : RX_CNT;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            RX_CNT: begin
               // Byte count must match twice the register count and fit the limit.
               if (field_q[15:7] == 9'd0 && mb_rxd == {field_q[6:0], 1'b0} &&
                   mb_rxd != 8'd0 && mb_rxd <= MAX_BYTES) begin
                  bcnt_d  = mb_rxd;
                  cnt_d   = 8'd0;
                  state_d = RX_DATA;
               end else begin
                  state_d    = DISCARD;
                  err_flag_d = 1'b1;
               end
            end
            RX_DATA: begin
               wr_en_d   = 1'b1;
               wr_idx_d  = cnt_q;
               wr_data_d = mb_rxd;
               if (cnt_q == bcnt_q - 8'd1) begin
                  cnt_d   = 8'd0;
                  state_d = RX_CRC;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            RX_CRC: begin
               if (cnt_q == 8'd0) begin
                  cnt_d = 8'd1;
               end else begin
                  cnt_d      = 8'd0;
                  state_d    = DISCARD;
                  err_flag_d = 1'b0;
                  if (crc_new == 16'h0000) begin
                     rx_done_d = 1'b1;
                     mb_fun_d  = fun_q;
                     mb_addr_d = field_q[31:16];
                     mb_num_d  = field_q[15:0];
                  end else begin
                     rx_err_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end else if (expire) begin
         case (state_q)
            IDLE: ;
            DISCARD: begin
               state_d    = IDLE;
               rx_err_d   = err_flag_q;
               err_flag_d = 1'b0;
            end
            default: begin
               // Truncated frame.
               state_d    = IDLE;
               rx_err_d   = 1'b1;
               err_flag_d = 1'b0;
               cnt_d      = 8'd0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         crc_q      <= 16'hFFFF;
         gap_q      <= 16'd0;
         cnt_q      <= 8'd0;
         bcnt_q     <= 8'd0;
         fun_q      <= 8'd0;
         field_q    <= 32'd0;
         err_flag_q <= 1'b0;
         mb_fun_q   <= 8'd0;
         mb_addr_q  <= 16'd0;
         mb_num_q   <= 16'd0;
         wr_en_q    <= 1'b0;
         wr_idx_q   <= 8'd0;
         wr_data_q  <= 8'd0;
         rx_done_q  <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         gap_q      <= gap_d;
         cnt_q      <= cnt_d;
         bcnt_q     <= bcnt_d;
         fun_q      <= fun_d;
         field_q    <= field_d;
         err_flag_q <= err_flag_d;
         mb_fun_q   <= mb_fun_d;
         mb_addr_q  <= mb_addr_d;
         mb_num_q   <= mb_num_d;
         wr_en_q    <= wr_en_d;
         wr_idx_q   <= wr_idx_d;
         wr_data_q  <= wr_data_d;
         rx_done_q  <= rx_done_d;
         rx_err_q   <= rx_err_d;
      end
   end

   assign mb_fun  = mb_fun_q;
   assign mb_addr = mb_addr_q;
   assign mb_num  = mb_num_q;
   assign wr_en   = wr_en_q;
   assign wr_idx  = wr_idx_q;
   assign wr_data = wr_data_q;
   assign rx_done = rx_done_q;
   assign rx_err  = rx_err_q;

endmodule
